instr_issuer: RTL

Instruction encoder and issuer that drives the instructdecoder `id` input. Instruction fields (opcode, rd, rs, imm) are written in through a load port and packed into 18-bit words in a small program store. On `start`, the stored program is replayed to the decoder, one word every ISSUE_GAP cycles, until a HALT word is issued. It replaces hand-written `id` stimulus and forms the fetch/issue front end of the processor.

---
 rtl/instr_issuer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_issuer.sv
// Fetch/issue front end: packs loaded instruction fields into a small program
// store and replays it onto the decoder's id bus, one word every ISSUE_GAP cycles.
module instr_issuer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int ISSUE_GAP = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_en,
    input  logic [3:0]        load_op,
    input  logic [2:0]        load_rd,
    input  logic [2:0]        load_rs,
    input  logic [7:0]        load_imm,
    output logic              load_ready,
    input  logic              start,
    output logic [17:0]       id,
    output logic              id_valid,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              load_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, HALTED} state_t;

    localparam logic [3:0]        HALT_OP   = 4'b1000;
    localparam logic [17:0]       HALT_WORD = {HALT_OP, 14'd0};
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]        GAP_INIT  = 8'(ISSUE_GAP - 1);

    state_t              state_reg, state_next;
    logic [17:0]         mem [DEPTH];
    logic [ADDR_W:0]     count_reg, count_next;
    logic [ADDR_W:0]     count_last;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [ADDR_W-1:0]   rd_addr;
    logic [17:0]         id_reg;
    logic [7:0]          gap_reg, gap_next;
    logic                load_err_reg, load_err_next;
    logic                idle_like, clear_ok, load_ok, hold_done, last_word;
    logic                issue_mem, issue_halt;

    assign idle_like  = (state_reg == IDLE) || (state_reg == HALTED);
    assign load_ready = idle_like && (count_reg < DEPTH_C);
    assign clear_ok   = clear && idle_like;
    assign load_ok    = load_en && load_ready && !clear_ok;
    assign count_last = count_reg - 1'b1;
    assign last_word  = ({1'b0, pc_reg} == count_last);
    // The final hold cycle of a word: either the ISSUE cycle itself or the last GAP cycle.
    assign hold_done  = ((state_reg == ISSUE) && (ISSUE_GAP == 1)) ||
                        ((state_reg == GAP) && (gap_reg == 8'd1));

    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        pc_next       = pc_reg;
        gap_next      = gap_reg;
        load_err_next = load_err_reg;
        rd_addr       = pc_reg;
        issue_mem     = 1'b0;
        issue_halt    = 1'b0;

        if (load_en && !load_ready && !clear_ok) begin
            load_err_next = 1'b1;
        end

        case (state_reg)
            IDLE, HALTED: begin
                if (clear_ok) begin
                    count_next    = '0;
                    load_err_next = 1'b0;
                    state_next    = IDLE;
                end else if (load_ok) begin
                    count_next = count_reg + 1'b1;
                end else if (start && !load_en && (count_reg != '0)) begin
                    state_next = ISSUE;
                    pc_next    = '0;
                    rd_addr    = '0;
                    issue_mem  = 1'b1;
                end
            end
            ISSUE: begin
                if (ISSUE_GAP > 1) begin
                    state_next = GAP;
                    gap_next   = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_reg > 8'd1) begin
                    gap_next = gap_reg - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The implicit halt word carries HALT_OP, so it lands in HALTED through the first branch.
        if (hold_done) begin
            if (id_reg[17:14] == HALT_OP) begin
                state_next = HALTED;
            end else if (last_word) begin
                state_next = ISSUE;
                issue_halt = 1'b1;
            end else begin
                state_next = ISSUE;
                pc_next    = pc_reg + 1'b1;
                rd_addr    = pc_reg + 1'b1;
                issue_mem  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[count_reg[ADDR_W-1:0]] <= {load_op, load_rd, load_rs, load_imm};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            pc_reg       <= '0;
            gap_reg      <= '0;
            load_err_reg <= 1'b0;
            id_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            pc_reg       <= pc_next;
            gap_reg      <= gap_next;
            load_err_reg <= load_err_next;
            if (issue_mem) begin
                id_reg <= mem[rd_addr];
            end else if (issue_halt) begin
                id_reg <= HALT_WORD;
            end
        end
    end

    assign id       = id_reg;
    assign id_valid = (state_reg == ISSUE);
    assign busy     = (state_reg == ISSUE) || (state_reg == GAP);
    assign halted   = (state_reg == HALTED);
    assign pc       = pc_reg;
    assign load_err = load_err_reg;

endmodule
